// File: rtl/drop_scheduler.sv
// drop_scheduler: round controller that launches, scores and re-arms the falling-ingredient lanes.
module drop_scheduler #(
  parameter int LANES = 4,
  parameter int ROUND_DROPS = 16,
  parameter int MIN_GAP = 20,
  parameter int CATCH_LO = 56,
  parameter int CATCH_HI = 63,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic game_start,
  input  logic [LANES-1:0] catch_btn,
  input  logic [7*LANES-1:0] lane_y,
  output logic [LANES-1:0] lane_start,
  output logic [9*LANES-1:0] lane_delay,
  output logic [LANES-1:0] lane_rearm,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic [4:0] drops_issued,
  output logic busy,
  output logic done
);
  localparam int GW = MIN_GAP > 1 ? $clog2(MIN_GAP) : 1;
  localparam logic [6:0] Y_IDLE = 7'd70;
  localparam logic [6:0] Y_LAND = 7'd80;
  typedef enum logic [1:0] {IDLE, RUN, DONE} top_t;
  typedef enum logic [1:0] {OFF, FALL, REARM, FLUSH} lane_t;
  top_t top, top_n;
  lane_t st [LANES];
  lane_t st_n [LANES];
  logic [LANES-1:0] caught, caught_n;
  logic [2:0] rr, rr_n;
  logic [7:0] lfsr, lfsr_n;
  logic [GW-1:0] gap, gap_n;
  logic [7:0] score_n, misses_n;
  logic [4:0] drops_n;
  logic [9*LANES-1:0] delay_n;
  logic [3:0] n_hit, n_miss;
  logic [8:0] score_sum, miss_sum;
  logic launch, all_off;
  int sel, j;
  always_comb begin
    top_n = top;
    st_n = st;
    caught_n = caught;
    rr_n = rr;
    lfsr_n = lfsr;
    gap_n = gap == '0 ? '0 : gap - 1'b1;
    drops_n = drops_issued;
    delay_n = lane_delay;
    n_hit = '0;
    n_miss = '0;
    launch = 1'b0;
    sel = 0;
    j = 0;
    all_off = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      all_off = all_off && st[i] == OFF;
      case (st[i])
        FALL:
          if (lane_y[7*i +: 7] == Y_LAND) begin
            st_n[i] = REARM;
            n_hit = n_hit + {3'b0, caught[i]};
            n_miss = n_miss + {3'b0, !caught[i]};
          end else if (catch_btn[i] && int'(lane_y[7*i +: 7]) >= CATCH_LO && int'(lane_y[7*i +: 7]) <= CATCH_HI)
            caught_n[i] = 1'b1;
        FLUSH: st_n[i] = lane_y[7*i +: 7] == Y_LAND ? REARM : FLUSH;
        REARM: st_n[i] = OFF;
        default:
          if (top == RUN && lane_y[7*i +: 7] != Y_IDLE)
            st_n[i] = lane_y[7*i +: 7] == Y_LAND ? REARM : FLUSH;
      endcase
    end
    // round-robin search for an idle lane, starting at rr
    if (top == RUN && drops_issued < 5'(ROUND_DROPS) && gap == '0)
      for (int k = 0; k < LANES; k++) begin
        j = (int'(rr) + k) % LANES;
        if (!launch && st[j] == OFF && lane_y[7*j +: 7] == Y_IDLE) begin
          launch = 1'b1;
          sel = j;
        end
      end
    if (launch) begin
      st_n[sel] = FALL;
      caught_n[sel] = 1'b0;
      delay_n[9*sel +: 9] = {1'b0, lfsr};
      drops_n = drops_issued + 5'd1;
      rr_n = 3'((sel + 1) % LANES);
      gap_n = GW'(MIN_GAP - 1);
      lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    score_sum = {1'b0, score} + {5'b0, n_hit};
    miss_sum = {1'b0, misses} + {5'b0, n_miss};
    score_n = score_sum[8] ? 8'hFF : score_sum[7:0];
    misses_n = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    if (top != RUN && game_start) begin
      top_n = RUN;
      score_n = '0;
      misses_n = '0;
      drops_n = '0;
      gap_n = '0;
      caught_n = '0;
    end else if (top == RUN && drops_issued == 5'(ROUND_DROPS) && all_off)
      top_n = DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      top <= IDLE;
      st <= '{default: OFF};
      caught <= '0;
      rr <= '0;
      lfsr <= LFSR_SEED;
      gap <= '0;
      score <= '0;
      misses <= '0;
      drops_issued <= '0;
      lane_delay <= '0;
      lane_start <= '0;
      lane_rearm <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      top <= top_n;
      st <= st_n;
      caught <= caught_n;
      rr <= rr_n;
      lfsr <= lfsr_n;
      gap <= gap_n;
      score <= score_n;
      misses <= misses_n;
      drops_issued <= drops_n;
      lane_delay <= delay_n;
      for (int i = 0; i < LANES; i++) begin
        lane_start[i] <= st_n[i] != OFF;
        lane_rearm[i] <= st_n[i] == REARM;
      end
      busy <= top_n == RUN;
      done <= top_n == DONE;
    end
endmodule

// File: tb/tb_drop_scheduler.sv
// tb_drop_scheduler: random lane traffic and catches, checked event-by-event against a reference scheduler model.
module tb_drop_scheduler;
  localparam int L = 4, RD = 16, MG = 20, CLO = 56, CHI = 63;
  localparam int OFF = 0, FALL = 1, REARM = 2, FLUSH = 3;
  localparam int IDLE = 0, RUN = 1, DONE = 2;

  logic clk = 0, reset = 1, game_start = 0;
  logic [L-1:0] catch_btn = '0;
  logic [7*L-1:0] lane_y = {L{7'd70}};
  logic [L-1:0] lane_start, lane_rearm;
  logic [9*L-1:0] lane_delay;
  logic [7:0] score, misses;
  logic [4:0] drops_issued;
  logic busy, done;

  drop_scheduler #(.LANES(L), .ROUND_DROPS(RD), .MIN_GAP(MG), .CATCH_LO(CLO), .CATCH_HI(CHI),
                   .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .catch_btn(catch_btn), .lane_y(lane_y),
    .lane_start(lane_start), .lane_delay(lane_delay), .lane_rearm(lane_rearm), .score(score),
    .misses(misses), .drops_issued(drops_issued), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {int cyc; int kind; int lane; int v0; int v1; int v2;} ev_t;
  ev_t q[$];
  ev_t tmp;
  int checks = 0, errors = 0, cyc = 0;

  int ly[L] = '{default: 70};
  int wt[L] = '{default: 0};
  bit hold[L] = '{default: 0};
  logic [L-1:0] p_start = '0, p_rearm = '0;
  logic p_busy = 0, p_done = 0;

  int m_top, m_rr, m_gap, m_score, m_miss, m_drops, m_lfsr;
  int m_ls[L], m_cg[L], m_dly[L];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int lane, input int a, input int b, input int c);
    ev_t e;
    e.cyc = cyc; e.kind = kind; e.lane = lane; e.v0 = a; e.v1 = b; e.v2 = c;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_top = IDLE; m_rr = 0; m_gap = 0; m_score = 0; m_miss = 0; m_drops = 0; m_lfsr = 'hA5;
    for (int i = 0; i < L; i++) begin m_ls[i] = OFF; m_cg[i] = 0; m_dly[i] = 0; end
  endtask

  task automatic model_step();
    int nls[L];
    int ncg[L];
    int hit = 0, mis = 0, pick = -1, ntop = m_top, old_drops = m_drops;
    bit idle_all = 1;
    for (int i = 0; i < L; i++) begin
      nls[i] = m_ls[i];
      ncg[i] = m_cg[i];
      idle_all &= m_ls[i] == OFF;
      if (m_ls[i] == FALL && ly[i] == 80) begin
        nls[i] = REARM;
        if (m_cg[i] != 0) hit++; else mis++;
      end else if (m_ls[i] == FALL && catch_btn[i] && ly[i] >= CLO && ly[i] <= CHI) ncg[i] = 1;
      else if (m_ls[i] == FLUSH && ly[i] == 80) nls[i] = REARM;
      else if (m_ls[i] == REARM) nls[i] = OFF;
      else if (m_ls[i] == OFF && m_top == RUN && ly[i] != 70) nls[i] = ly[i] == 80 ? REARM : FLUSH;
    end
    if (m_top == RUN && m_drops < RD && m_gap == 0)
      for (int k = 0; k < L && pick < 0; k++)
        if (m_ls[(m_rr + k) % L] == OFF && ly[(m_rr + k) % L] == 70) pick = (m_rr + k) % L;
    if (pick >= 0) begin
      nls[pick] = FALL;
      ncg[pick] = 0;
      m_dly[pick] = m_lfsr;
      m_drops++;
      m_rr = (pick + 1) % L;
      m_gap = MG - 1;
      m_lfsr = ((m_lfsr << 1) | (^(m_lfsr & 'hB8))) & 255;
    end else if (m_gap > 0) m_gap--;
    m_score = m_score + hit > 255 ? 255 : m_score + hit;
    m_miss = m_miss + mis > 255 ? 255 : m_miss + mis;
    if (m_top != RUN && game_start) begin
      ntop = RUN; m_score = 0; m_miss = 0; m_drops = 0; m_gap = 0;
      for (int i = 0; i < L; i++) ncg[i] = 0;
    end else if (m_top == RUN && old_drops == RD && idle_all) ntop = DONE;
    for (int i = 0; i < L; i++) if (m_ls[i] == OFF && nls[i] != OFF) push(0, i, m_dly[i], m_drops, 0);
    for (int i = 0; i < L; i++) if (m_ls[i] != OFF && nls[i] == OFF) push(1, i, 0, 0, 0);
    for (int i = 0; i < L; i++) if (m_ls[i] != REARM && nls[i] == REARM) push(2, i, m_score, m_miss, 0);
    if (ntop != m_top) push(3, 0, (ntop == RUN ? 2 : 0) + (ntop == DONE ? 1 : 0), m_score + m_miss, m_drops);
    m_top = ntop;
    for (int i = 0; i < L; i++) begin m_ls[i] = nls[i]; m_cg[i] = ncg[i]; end
  endtask

  task automatic observe(input int kind, input int lane, input int a, input int b, input int c);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind %0d lane %0d at cycle %0d: got %0d/%0d/%0d, none required", kind, lane, cyc, a, b, c);
    end else begin
      tmp = q.pop_front();
      if (tmp.cyc != cyc || tmp.kind != kind || tmp.lane != lane || tmp.v0 != a || tmp.v1 != b || tmp.v2 != c) begin
        errors++;
        $display("FAIL event: got cyc %0d kind %0d lane %0d vals %0d/%0d/%0d, expected cyc %0d kind %0d lane %0d vals %0d/%0d/%0d",
                 cyc, kind, lane, a, b, c, tmp.cyc, tmp.kind, tmp.lane, tmp.v0, tmp.v1, tmp.v2);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) model_reset(); else model_step();
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) if (lane_start[i] && !p_start[i]) observe(0, i, int'(lane_delay[9*i +: 9]), int'(drops_issued), 0);
      for (int i = 0; i < L; i++) if (!lane_start[i] && p_start[i]) observe(1, i, 0, 0, 0);
      for (int i = 0; i < L; i++) if (lane_rearm[i] && !p_rearm[i]) observe(2, i, int'(score), int'(misses), 0);
      if ({busy, done} != {p_busy, p_done}) observe(3, 0, int'({busy, done}), int'(score) + int'(misses), int'(drops_issued));
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        tmp = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing event kind %0d lane %0d: got nothing at cycle %0d, expected vals %0d/%0d/%0d at cycle %0d",
                 tmp.kind, tmp.lane, cyc, tmp.v0, tmp.v1, tmp.v2, tmp.cyc);
      end
    end
    for (int i = 0; i < L; i++) begin
      if (p_start[i]) begin
        if (ly[i] == 80) begin
          if (p_rearm[i]) ly[i] = 70;
        end else if (ly[i] == 70) begin
          if (wt[i] == 2) begin wt[i] = 0; ly[i] = 0; end else wt[i]++;
        end else if (!(hold[i] && ly[i] == 64) && (ly[i] == 64 || $urandom_range(3) != 0))
          ly[i] = ly[i] == 64 ? 80 : ly[i] + 1;
      end
      catch_btn[i] = $urandom_range(7) == 0;
      lane_y[7*i +: 7] = 7'(ly[i]);
    end
    p_start = lane_start;
    p_rearm = lane_rearm;
    p_busy = busy;
    p_done = done;
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk("reset lane_start", int'(lane_start), 0);
    chk("reset lane_rearm", int'(lane_rearm), 0);
    chk("reset lane_delay zero", int'(lane_delay != '0), 0);
    chk("reset score", int'(score), 0);
    chk("reset misses", int'(misses), 0);
    chk("reset drops", int'(drops_issued), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    @(posedge clk); #2 reset = 0;
    @(negedge clk) game_start = 1;
    @(negedge clk) game_start = 0;
    chk("busy after start", int'(busy), 1);
    hold[1] = 1; hold[2] = 1;
    for (int n = 0; n < 100 && !lane_start[0]; n++) @(negedge clk);
    chk("first launch lane 0", int'(lane_start[0]), 1);
    chk("first delay", int'(lane_delay[8:0]), 'h0A5);
    t0 = cyc;
    for (int n = 0; n < 100 && !lane_start[1]; n++) @(negedge clk);
    chk("second launch lane 1", int'(lane_start[1]), 1);
    chk("second delay", int'(lane_delay[17:9]), 'h04A);
    chk("launch spacing", cyc - t0, MG);
    for (int n = 0; n < 2000 && !(ly[1] == 64 && ly[2] == 64); n++) @(negedge clk);
    chk("lanes 1,2 parked at 64", int'(ly[1] == 64 && ly[2] == 64), 1);
    hold[1] = 0; hold[2] = 0;
    for (int n = 0; n < 10 && !lane_rearm[1]; n++) @(negedge clk);
    chk("lane 1 rearm", int'(lane_rearm[1]), 1);
    chk("lane 2 rearm same cycle", int'(lane_rearm[2]), 1);
    for (int n = 0; n < 5000 && !done; n++) @(negedge clk);
    chk("round 1 done", int'(done), 1);
    chk("round 1 drops", int'(drops_issued), RD);
    chk("round 1 score+misses", int'(score) + int'(misses), RD);
    @(negedge clk) game_start = 1;
    @(negedge clk) game_start = 0;
    chk("restart busy", int'(busy), 1);
    chk("restart done", int'(done), 0);
    chk("restart score", int'(score), 0);
    chk("restart misses", int'(misses), 0);
    chk("restart drops", int'(drops_issued), 0);
    for (int n = 0; n < 3000 && !(lane_start[3] && ly[3] == 30); n++) @(negedge clk);
    chk("lane 3 mid-fall", int'(lane_start[3] && ly[3] == 30), 1);
    @(posedge clk); #2 reset = 1;
    q.delete();
    @(negedge clk);
    chk("mid reset lane_start", int'(lane_start), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset drops", int'(drops_issued), 0);
    @(posedge clk); #2 reset = 0;
    @(negedge clk) game_start = 1;
    @(negedge clk) game_start = 0;
    for (int n = 0; n < 10 && !lane_start[3]; n++) @(negedge clk);
    chk("lane 3 flush start", int'(lane_start[3]), 1);
    for (int n = 0; n < 300 && !lane_rearm[3]; n++) @(negedge clk);
    chk("lane 3 flush rearm", int'(lane_rearm[3]), 1);
    chk("flush landing unscored", int'(score) + int'(misses), 0);
    for (int n = 0; n < 5000 && !done; n++) @(negedge clk);
    chk("round 2 done", int'(done), 1);
    chk("round 2 drops", int'(drops_issued), RD);
    chk("round 2 score+misses", int'(score) + int'(misses), RD);
    repeat (5) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/drop_scheduler.md
# drop_scheduler

Round controller for the falling-ingredient game. It owns up to `LANES` drop lanes. For each lane it launches a drop with a pseudo-random start delay, watches the lane's y position, and latches player catches inside a catch window. When a drop lands it scores a catch or a miss and re-arms the lane. It sits between the game-top FSM (start/done) and the per-lane drop generators, and runs on the same slow game clock.

## Interface
- `LANES`, 4, number of drop lanes (1–8)
- `ROUND_DROPS`, 16, drops issued per round (1–31)
- `MIN_GAP`, 20, minimum cycles between successive launches (≥1)
- `CATCH_LO`, 56, lowest y counted as catchable
- `CATCH_HI`, 63, highest y counted as catchable
- `LFSR_SEED`, 8'hA5, non-zero LFSR reset value
- `clk` in 1 — game clock, all logic on rising edge
- `reset` in 1 — asynchronous, active-high; returns the block to IDLE
- `game_start` in 1 — level, sampled each cycle; starts a round from IDLE or DONE
- `catch_btn` in LANES — per-lane catch request, level-sampled
- `lane_y` in 7*LANES — lane i y position at [7i+6:7i]
- `lane_start` out LANES — run enable to lane i
- `lane_delay` out 9*LANES — start delay to lane i at [9i+8:9i]
- `lane_rearm` out LANES — re-arm pulse to lane i
- `score` out 8 — catches this round
- `misses` out 8 — uncaught landings this round
- `drops_issued` out 5 — launches this round
- `busy` out 1 — high in RUN
- `done` out 1 — high in DONE

## Operation
- Lane contract:
  - y=70 idle; 0..64 falling; 80 landed.
  - A landed lane returns to 70 one edge after it sees rearm=1 while start=1.
  - With start=0 the lane freezes.
- Top FSM:
  - IDLE→RUN on `game_start`. On entry, clear `score`, `misses`, `drops_issued`, gap counter and `caught`.
  - RUN→DONE when `drops_issued==ROUND_DROPS` and every lane is OFF.
  - DONE→RUN on `game_start`, with the same clears.
  - `game_start` is ignored in RUN.
- Per-lane FSM, states OFF, FALL, REARM, FLUSH:
  - OFF: start=0, rearm=0.
  - FALL: start=1; the lane is counted.
  - REARM: start=1, rearm=1, held for exactly one cycle, then →OFF.
  - FLUSH: start=1; used to recover a lane that is not idle. Reaching y=80 →REARM with no scoring.
- Launch (RUN only). A lane is eligible when it is OFF and its `lane_y==70`. A launch happens when:
  - `drops_issued<ROUND_DROPS`,
  - gap counter==0, and
  - an eligible lane exists.
- Launch selection and effects:
  - Select the first eligible lane at or after `rr`, wrapping.
  - That lane →FALL, its `lane_delay` ← {1'b0, lfsr}, and its `caught` flag is cleared.
  - `drops_issued`++, `rr` ← selected+1 mod LANES, gap counter ← MIN_GAP−1, and the LFSR advances.
  - At most one launch per cycle.
- Gap counter decrements to 0 and saturates there.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts only on a launch.
- Recovery (RUN only), for an OFF lane:
  - `lane_y==80` → REARM with no scoring.
  - `lane_y` not 70 and not 80 → FLUSH.
- Catch: in FALL, `catch_btn[i]` with CATCH_LO≤`lane_y`≤CATCH_HI sets `caught[i]`. It is sticky until the next launch. Catches outside the window, or in other states, are ignored with no penalty.
- Landing: a lane in FALL that sees `lane_y==80` →REARM.
  - If `caught` is set, `score`++; otherwise `misses`++.
- Simultaneous landings in one cycle add the per-type count of those landings: `score` += number of caught landings, `misses` += number of uncaught landings. Both counters saturate at 255.
- A catch asserted on the landing cycle is ignored, because y=80 is outside the window.
- In IDLE and DONE, lanes in FALL or FLUSH continue until they land and REARM. New launches and recovery are disabled.

## Timing
- Reset values:
  - all `lane_start`, `lane_rearm` = 0; `lane_delay` = 0
  - `score`, `misses`, `drops_issued` = 0
  - `busy`, `done` = 0; `rr` = 0; lfsr = LFSR_SEED; all lanes OFF; top state IDLE
- All outputs are registered.
- `game_start` high at edge t: `busy`=1 after t. The first `lane_start` rises after edge t+1.
- Launch spacing: exactly MIN_GAP cycles when a lane is eligible; longer otherwise.
- Landing sampled at edge t: `lane_rearm`=1 and the counter update are visible after t. After t+1, `lane_rearm`=0 and `lane_start`=0. The lane is re-eligible at t+2.
- `done` rises the cycle after the last lane reaches OFF.
- `reset` asserted mid-round clears everything immediately. In-flight lanes freeze and are recovered by FLUSH/REARM in the next round.

## Test plan
- Reset, then `game_start` pulse, LANES=4, MIN_GAP=20, lanes modelled: `lane_start` rises on lanes 0,1,2,3 at 20-cycle spacing; delays are successive LFSR values starting 0x0A5.
- Lane 0 `lane_y`=60 with `catch_btn[0]`=1, then y=80 → `lane_rearm[0]` pulses one cycle; `score`=1; `misses`=0.
- No catch, y=80 → `misses`++. Catch at y=50 (outside window) → ignored, and the landing counts as a miss.
- Lanes 1 and 2 land in the same cycle, one caught and one not → `score`+1 and `misses`+1 in the same cycle.
- Full round, ROUND_DROPS=16: `drops_issued`=16, then `done`=1 after the last rearm with `score+misses`=16. `game_start` in DONE clears the counters and re-enters RUN.
- Assert `reset` mid-fall with lane 3 at y=30, then start a new round → lane 3 enters FLUSH; its landing is not scored; it relaunches only after y=70.
